// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state and helpers for the multi-cycle execute-stage ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_MUL   = 4'b0100;
    localparam logic [3:0] OP_MULHU = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_XOR   = 4'b1010;
    localparam logic [3:0] OP_SRA   = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_REMU  = 4'b1110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        MUL = 1'b0,
        DIV = 1'b1
    } mode_t;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic mode_t iter_mode(input logic [3:0] op);
        return ((op == OP_DIVU) || (op == OP_REMU)) ? DIV : MUL;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative unsigned multiply (shift-add) / divide (restoring).
// res_lo/res_hi present the value the registers take on the current step, so the
// owner can capture the final answer on the same edge that performs the last step.
// MUL: res_hi:res_lo = product.  DIV: res_lo = quotient, res_hi = remainder.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             start,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc_q, sreg_q, opnd_q;
    logic [CW-1:0]    cnt_q;
    mode_t            mode_q;

    logic [WIDTH:0]   sum, rs;
    logic             ge;
    logic [WIDTH-1:0] acc_n, sreg_n;

    // One step of the selected algorithm on the current register contents.
    always_comb begin
        sum = {1'b0, acc_q} + (sreg_q[0] ? {1'b0, opnd_q} : '0);
        rs  = {acc_q, sreg_q[WIDTH-1]};
        ge  = (rs >= {1'b0, opnd_q});
        if (mode_q == DIV) begin
            // When ge, rs - divisor < divisor, so the low-WIDTH subtraction is exact.
            acc_n  = ge ? (rs[WIDTH-1:0] - opnd_q) : rs[WIDTH-1:0];
            sreg_n = {sreg_q[WIDTH-2:0], ge};
        end else begin
            acc_n  = sum[WIDTH:1];
            sreg_n = {sum[0], sreg_q[WIDTH-1:1]};
        end
    end

    assign res_lo = sreg_n;
    assign res_hi = acc_n;
    assign done   = (cnt_q == CW'(1));

    // Load on start, then step once per cycle until the counter empties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            sreg_q <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            mode_q <= MUL;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (start) begin
            acc_q  <= '0;
            sreg_q <= op_a;
            opnd_q <= op_b;
            cnt_q  <= CW'(WIDTH);
            mode_q <= mode;
        end else if (cnt_q != '0) begin
            acc_q  <= acc_n;
            sreg_q <= sreg_n;
            cnt_q  <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready on both sides; one operation in flight.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] single_res, iter_res;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic             md_done, accept, start;
    logic [SHW-1:0]   shamt;

    assign accept = (state_q == IDLE) && in_valid && !flush;
    assign start  = accept && is_iterative(operation);
    assign shamt  = in_y[SHW-1:0];

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .start  (start),
        .mode   (iter_mode(operation)),
        .op_a   (in_x),
        .op_b   (in_y),
        .done   (md_done),
        .res_lo (md_lo),
        .res_hi (md_hi)
    );

    // Single-cycle result mux; unknown codes pass X through.
    always_comb begin
        single_res = in_x;
        case (operation)
            OP_AND:  single_res = in_x & in_y;
            OP_OR:   single_res = in_x | in_y;
            OP_ADD:  single_res = in_x + in_y;
            OP_SUB:  single_res = in_x - in_y;
            OP_SLT:  single_res = WIDTH'($signed(in_x) < $signed(in_y));
            OP_SLTU: single_res = WIDTH'(in_x < in_y);
            OP_NOR:  single_res = ~(in_x | in_y);
            OP_XOR:  single_res = in_x ^ in_y;
            OP_SLL:  single_res = in_x << shamt;
            OP_SRL:  single_res = in_x >> shamt;
            OP_SRA:  single_res = $unsigned($signed(in_x) >>> shamt);
            default: single_res = in_x;
        endcase
    end

    // MUL and DIVU take the low half of the shared datapath, MULHU and REMU the high half.
    always_comb begin
        iter_res = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? md_lo : md_hi;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = is_iterative(operation) ? BUSY : DONE;
            BUSY: if (md_done)  state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Opcode and result capture; result only moves on the edge entering DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q <= operation;
            if (!is_iterative(operation)) result_q <= single_res;
        end else if ((state_q == BUSY) && md_done && !flush) begin
            result_q <= iter_res;
        end
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == BUSY);
        zero      = (state_q == DONE) && (result_q == '0);
        result    = result_q;
    end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised self-checking bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [3:0]  operation;
    logic [31:0] in_x, in_y, result;
    logic [31:0] last_exp;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit ref_iter(input logic [3:0] op);
        return op == 4'd4 || op == 4'd5 || op == 4'd13 || op == 4'd14;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
        logic [63:0]        prod;
        logic signed [31:0] sx;
        int                 sh;
        prod = 64'(x) * 64'(y);
        sx   = x;
        sh   = int'(y % 32);
        case (op)
            4'd0:  return x & y;
            4'd1:  return x | y;
            4'd2:  return x + y;
            4'd3:  return (x < y) ? 32'd1 : 32'd0;
            4'd4:  return prod[31:0];
            4'd5:  return prod[63:32];
            4'd6:  return x - y;
            4'd7:  return (sx < $signed(y)) ? 32'd1 : 32'd0;
            4'd8:  return x << sh;
            4'd9:  return x >> sh;
            4'd10: return x ^ y;
            4'd11: return $unsigned(sx >>> sh);
            4'd12: return ~(x | y);
            4'd13: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            4'd14: return (y == 0) ? x : x % y;
            default: return x;
        endcase
    endfunction

    // Wait (bounded) for in_ready on a falling edge, then present a request.
    task automatic present(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                           input logic ordy, input string tag);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready"}, {31'b0, in_ready}, 32'd1);
        operation = op; in_x = x; in_y = y; out_ready = ordy; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input string tag);
        int          lat, bcnt;
        logic [31:0] exp;
        exp = ref_alu(op, x, y);
        present(op, x, y, 1'b1, tag);
        lat  = 1;
        bcnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1 lat++;
        end
        check({tag, " latency"}, 32'(lat), ref_iter(op) ? 32'd33 : 32'd1);
        check({tag, " busy_cycles"}, 32'(bcnt), ref_iter(op) ? 32'd32 : 32'd0);
        check({tag, " result"}, result, exp);
        check({tag, " zero"}, {31'b0, zero}, {31'b0, exp == 32'd0});
        last_exp = exp;
    endtask

    initial begin
        int seen;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        operation = '0; in_x = '0; in_y = '0; last_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", {31'b0, in_ready}, 32'd1);
        check("rst out_valid", {31'b0, out_valid}, 32'd0);
        check("rst result", result, 32'd0);
        check("rst zero", {31'b0, zero}, 32'd0);
        check("rst busy", {31'b0, busy}, 32'd0);
        @(negedge clk) reset = 1'b0;

        // Directed cases.
        do_op(4'd2,  32'h7FFF_FFFF, 32'd1, "add_ovf");
        do_op(4'd6,  32'd5, 32'd5, "sub_zero");
        do_op(4'd7,  32'hFFFF_FFFF, 32'd1, "slt");
        do_op(4'd3,  32'hFFFF_FFFF, 32'd1, "sltu");
        do_op(4'd11, 32'h8000_0000, 32'h21, "sra");
        do_op(4'd4,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul");
        do_op(4'd5,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
        do_op(4'd13, 32'd100, 32'd7, "divu");
        do_op(4'd14, 32'd100, 32'd7, "remu");
        do_op(4'd13, 32'd5, 32'd0, "divu_by0");
        do_op(4'd14, 32'd5, 32'd0, "remu_by0");
        do_op(4'd15, 32'h1234_5678, 32'd9, "pass");

        // Randomised traffic, biased towards small divisors.
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] x, y;
            op = 4'($urandom_range(0, 15));
            x  = $urandom;
            y  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            do_op(op, x, y, "rand");
        end

        // Back-pressure in DONE: result held, new requests ignored.
        present(4'd2, 32'd3, 32'd4, 1'b0, "hold");
        check("hold out_valid", {31'b0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            operation = 4'd6; in_x = 32'd9; in_y = 32'd1; in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("hold result", result, 32'd7);
            check("hold in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release out_valid", {31'b0, out_valid}, 32'd0);
        check("release in_ready", {31'b0, in_ready}, 32'd1);
        check("release result", result, 32'd7);
        last_exp = 32'd7;

        // Flush together with a request in IDLE: not accepted.
        @(negedge clk);
        operation = 4'd2; in_x = 32'd1; in_y = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        check("idle_flush out_valid", {31'b0, out_valid}, 32'd0);
        check("idle_flush in_ready", {31'b0, in_ready}, 32'd1);

        // Flush at the tenth BUSY cycle.
        present(4'd4, 32'hFFFF_FFFF, 32'd3, 1'b1, "flush");
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush busy", {31'b0, busy}, 32'd0);
        check("flush in_ready", {31'b0, in_ready}, 32'd1);
        check("flush out_valid", {31'b0, out_valid}, 32'd0);
        check("flush result", result, last_exp);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        check("flush no_report", 32'(seen), 32'd0);

        // Asynchronous reset in the middle of a divide.
        present(4'd13, 32'd1000, 32'd3, 1'b1, "arst");
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst in_ready", {31'b0, in_ready}, 32'd1);
        check("arst out_valid", {31'b0, out_valid}, 32'd0);
        check("arst result", result, 32'd0);
        check("arst zero", {31'b0, zero}, 32'd0);
        check("arst busy", {31'b0, busy}, 32'd0);
        @(negedge clk) reset = 1'b0;
        do_op(4'd13, 32'd1000, 32'd3, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
